// File: rtl/cnc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : cnc_pkg                                                       |
// | Brief  : Shared definitions for the step generator: FSM state enum     |
// |          and default width/timing constants.                           |
// | Ports  : none (package)                                                |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
package cnc_pkg;

  localparam int DEF_STEPS_WIDTH  = 16;
  localparam int DEF_PERIOD_WIDTH = 24;
  localparam int DEF_PULSE_WIDTH  = 4;
  localparam int DEF_DIR_SETUP    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } step_state_t;

endpackage
`default_nettype wire

// File: rtl/step_gen_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : step_gen_timer                                                |
// | Brief  : Loadable down-counter that times the SETUP/HIGH/LOW phases.   |
// |          Loading N makes zero assert N cycles after the load edge.     |
// | Ports  : clk      in   system clock                                    |
// |          sclr     in   synchronous active-high reset                   |
// |          load     in   load load_val on this edge                      |
// |          load_val in   value to load (remaining cycles minus one)      |
// |          zero     out  count has reached zero                          |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module step_gen_timer #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (sclr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/step_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : step_gen                                                      |
// | Brief  : Step/direction pulse generator. Accepts a command (direction, |
// |          step count, period), waits a direction setup time, then emits |
// |          fixed-width step pulses at the commanded period while         |
// |          tracking a signed 32-bit position.                            |
// | Config : define STEP_GEN_ABORT_EN to add the abort input.              |
// | Ports  : clk, sclr (sync active-high reset)                            |
// |          cmd_valid/cmd_ready handshake, cmd_dir, cmd_steps, cmd_period |
// |          step, dir (registered), busy, done (1-cycle pulse), pos       |
// |          abort (only with STEP_GEN_ABORT_EN)                           |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module step_gen
  import cnc_pkg::*;
#(
  parameter int STEPS_WIDTH  = DEF_STEPS_WIDTH,
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter int PULSE_WIDTH  = DEF_PULSE_WIDTH,
  parameter int DIR_SETUP    = DEF_DIR_SETUP
) (
  input  logic                    clk,
  input  logic                    sclr,
`ifdef STEP_GEN_ABORT_EN
  input  logic                    abort,
`endif
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [STEPS_WIDTH-1:0]  cmd_steps,
  input  logic [PERIOD_WIDTH-1:0] cmd_period,
  output logic                    step,
  output logic                    dir,
  output logic                    busy,
  output logic                    done,
  output logic signed [31:0]      pos
);

  // One extra bit so the 2*PULSE_WIDTH floor always fits.
  localparam int                TW         = PERIOD_WIDTH + 1;
  localparam logic [TW-1:0]     MIN_PERIOD = TW'(2 * PULSE_WIDTH);
  localparam logic [TW-1:0]     SETUP_LOAD = TW'(DIR_SETUP - 1);
  localparam logic [TW-1:0]     HIGH_LOAD  = TW'(PULSE_WIDTH - 1);

  step_state_t            state, state_nxt;
  logic [TW-1:0]          period_q;
  logic [STEPS_WIDTH-1:0] remain_q;
  logic [TW-1:0]          period_ext;
  logic [TW-1:0]          period_eff;
  logic                   accept;
  logic                   abort_now;
  logic                   abort_held;
  logic                   tmr_load;
  logic [TW-1:0]          tmr_val;
  logic                   tmr_zero;
  logic                   fire;     // step rises on this edge
  logic                   finish;   // command completes on this edge

`ifdef STEP_GEN_ABORT_EN
  // An abort seen mid-pulse is remembered so the pulse can finish first.
  logic abort_pend;

  always_ff @(posedge clk) begin
    if (sclr || state_nxt == IDLE) begin
      abort_pend <= 1'b0;
    end else if (state == HIGH && abort) begin
      abort_pend <= 1'b1;
    end
  end

  assign abort_now  = abort;
  assign abort_held = abort_pend;
`else
  assign abort_now  = 1'b0;
  assign abort_held = 1'b0;
`endif

  assign cmd_ready  = (state == IDLE) && !sclr && !abort_now;
  assign accept     = cmd_valid && cmd_ready;
  assign busy       = (state != IDLE);
  assign period_ext = TW'(cmd_period);
  assign period_eff = (period_ext < MIN_PERIOD) ? MIN_PERIOD : period_ext;

  // Timer loads hold "cycles in the new state minus one".
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    fire      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          tmr_load  = 1'b1;
          tmr_val   = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (abort_now) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end else if (tmr_zero) begin
          if (remain_q == '0) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end else begin
            state_nxt = HIGH;
            tmr_load  = 1'b1;
            tmr_val   = HIGH_LOAD;
            fire      = 1'b1;
          end
        end
      end
      HIGH: begin
        if (tmr_zero) begin
          if (abort_now || abort_held) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end else begin
            state_nxt = LOW;
            tmr_load  = 1'b1;
            tmr_val   = period_q - TW'(PULSE_WIDTH) - TW'(1);
          end
        end
      end
      LOW: begin
        if (abort_now) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end else if (tmr_zero) begin
          if (remain_q == '0) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end else begin
            state_nxt = HIGH;
            tmr_load  = 1'b1;
            tmr_val   = HIGH_LOAD;
            fire      = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state    <= IDLE;
      step     <= 1'b0;
      dir      <= 1'b0;
      done     <= 1'b0;
      pos      <= '0;
      remain_q <= '0;
      period_q <= '0;
    end else begin
      state <= state_nxt;
      step  <= (state_nxt == HIGH);
      done  <= finish;
      if (accept) begin
        dir      <= cmd_dir;
        remain_q <= cmd_steps;
        period_q <= period_eff;
      end
      if (fire) begin
        remain_q <= remain_q - 1'b1;
        pos      <= dir ? (pos - 32'sd1) : (pos + 32'sd1);
      end
    end
  end

  step_gen_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .sclr     (sclr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

endmodule
`default_nettype wire

// File: tb/tb_step_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_step_gen                                                   |
// | Brief  : Self-checking bench for step_gen. A reference model turns     |
// |          each accepted command into a timeline of expected events      |
// |          (step rise, step fall, done) pushed to a queue; a monitor     |
// |          pops and compares whenever the DUT shows one of those events. |
// | Config : honours STEP_GEN_ABORT_EN (adds abort tests).                 |
// | Rev    : 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module tb_step_gen;

  localparam int SW    = 16;
  localparam int PWID  = 24;
  localparam int PULSE = 4;
  localparam int DS    = 2;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] pos;
    logic        dir;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             sclr = 1'b1;
  logic             cmd_valid, cmd_ready, cmd_dir;
  logic [SW-1:0]    cmd_steps;
  logic [PWID-1:0]  cmd_period;
  logic             step, dir, busy, done;
  logic signed [31:0] pos;
`ifdef STEP_GEN_ABORT_EN
  logic             abort;
`endif

  step_gen #(
    .STEPS_WIDTH  (SW),
    .PERIOD_WIDTH (PWID),
    .PULSE_WIDTH  (PULSE),
    .DIR_SETUP    (DS)
  ) dut (
    .clk        (clk),
    .sclr       (sclr),
`ifdef STEP_GEN_ABORT_EN
    .abort      (abort),
`endif
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .step       (step),
    .dir        (dir),
    .busy       (busy),
    .done       (done),
    .pos        (pos)
  );

  // cyc counts rising edges; "cycle k" is the interval after edge k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_err = 0;
  ev_t         q[$];
  logic [31:0] model_pos = '0;
  int          busy_lo = 1;
  int          busy_hi = 0;
  int          last_A = 0;
  logic [31:0] last_pos0 = '0;
  logic        step_prev = 1'b0;

  function automatic string kname(input int k);
    case (k)
      K_RISE:  return "rise";
      K_FALL:  return "fall";
      default: return "done";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic see_event(input int kind);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected %s at cycle %0d: got pos=%h dir=%b, expected no event",
               kname(kind), cyc, pos, dir);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.pos !== pos || e.dir !== dir) begin
        n_err++;
        $display("FAIL event: got %s cyc=%0d pos=%h dir=%b, expected %s cyc=%0d pos=%h dir=%b",
                 kname(kind), cyc, pos, dir, kname(e.kind), e.cyc, e.pos, e.dir);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!sclr) begin
      check("busy", {31'd0, busy}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
      if (step && !step_prev) see_event(K_RISE);
      if (!step && step_prev) see_event(K_FALL);
      if (done)               see_event(K_DONE);
    end
    step_prev = step;
  end

  // Drives one command when the DUT is ready and records the expected
  // event timeline. Called and returns on a falling edge.
  task automatic issue(input logic d, input int n, input int p);
    int w;
    int eff;
    int t;
    w = 0;
    while (!cmd_ready) begin
      cmd_valid  = 1'($urandom);
      cmd_dir    = 1'($urandom);
      cmd_steps  = SW'($urandom);
      cmd_period = PWID'($urandom);
      @(negedge clk);
      w++;
      if (w > 4000) begin
        n_cmp++;
        n_err++;
        cmd_valid = 1'b0;
        $display("FAIL ready_timeout at cycle %0d: got 0 expected 1", cyc);
        return;
      end
    end
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = SW'(n);
    cmd_period = PWID'(p);
    last_A     = cyc + 1;
    last_pos0  = model_pos;
    eff        = (p < 2 * PULSE) ? 2 * PULSE : p;
    for (int k = 0; k < n; k++) begin
      model_pos = d ? model_pos - 32'd1 : model_pos + 32'd1;
      q.push_back('{K_RISE, last_A + DS + k * eff, model_pos, d});
      q.push_back('{K_FALL, last_A + DS + k * eff + PULSE, model_pos, d});
    end
    t = (n == 0) ? last_A + DS : last_A + DS + n * eff;
    q.push_back('{K_DONE, t, model_pos, d});
    busy_lo = last_A;
    busy_hi = t - 1;
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_dir    = 1'($urandom);
    cmd_steps  = SW'($urandom);
    cmd_period = PWID'($urandom);
  endtask

  initial begin
    int w;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_steps  = '0;
    cmd_period = '0;
`ifdef STEP_GEN_ABORT_EN
    abort      = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_step",  {31'd0, step}, 32'd0);
    check("rst_dir",   {31'd0, dir}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_pos",   pos, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    sclr = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Directed: nominal run, clamped period, zero-step command.
    issue(1'b0, 3, 10);
    issue(1'b1, 2, 3);
    issue(1'b1, 0, 0);

    // Position wrap in both directions from a preset position.
    w = 0;
    while (!cmd_ready && w < 4000) begin @(negedge clk); w++; end
    force dut.pos = 32'sh7FFF_FFFF;
    #1;
    release dut.pos;
    model_pos = 32'h7FFF_FFFF;
    issue(1'b0, 1, 10);
    issue(1'b1, 1, 9);

    // Reset during the second cycle of a step pulse.
    issue(1'b0, 3, 10);
    while (cyc != last_A + 3) @(negedge clk);
    sclr = 1'b1;
    q.delete();
    busy_hi   = last_A + 3;
    model_pos = '0;
    @(negedge clk);
    check("sclr_step",  {31'd0, step}, 32'd0);
    check("sclr_pos",   pos, 32'd0);
    check("sclr_busy",  {31'd0, busy}, 32'd0);
    check("sclr_done",  {31'd0, done}, 32'd0);
    check("sclr_dir",   {31'd0, dir}, 32'd0);
    check("sclr_ready", {31'd0, cmd_ready}, 32'd0);
    sclr = 1'b0;

`ifdef STEP_GEN_ABORT_EN
    // Abort in the first HIGH cycle: pulse completes, then done.
    issue(1'b0, 3, 10);
    while (cyc != last_A + 2) @(negedge clk);
    abort = 1'b1;
    q.delete();
    model_pos = last_pos0 + 32'd1;
    q.push_back('{K_FALL, last_A + 6, model_pos, 1'b0});
    q.push_back('{K_DONE, last_A + 6, model_pos, 1'b0});
    busy_hi = last_A + 5;
    @(negedge clk);
    abort = 1'b0;
    // Abort in the first LOW cycle: done at the next edge.
    issue(1'b0, 3, 10);
    while (cyc != last_A + 6) @(negedge clk);
    abort = 1'b1;
    q.delete();
    model_pos = last_pos0 + 32'd1;
    q.push_back('{K_DONE, last_A + 7, model_pos, 1'b0});
    busy_hi = last_A + 6;
    @(negedge clk);
    abort = 1'b0;
`endif

    // Randomized commands with random idle gaps.
    repeat (30) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
      issue(1'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 20)));
    end

    w = 0;
    while (q.size() != 0 && w < 5000) begin @(negedge clk); w++; end
    repeat (5) @(negedge clk);
    check("drain_pending", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/step_gen.md
STEP_GEN -- requirements
Module: step_gen

Interface
REQ-001 Parameter STEPS_WIDTH, default 16: width of the commanded step count.
REQ-002 Parameter PERIOD_WIDTH, default 24: width of the step period in clk cycles.
REQ-003 Parameter PULSE_WIDTH, default 4: step-high time in clk cycles, >=1.
REQ-004 Parameter DIR_SETUP, default 2: clk cycles between dir update and the first step rise, >=1.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 sclr  input  1  reset, synchronous, active-high.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-009 cmd_dir  input  1  0 = forward (+1 per step), 1 = reverse (-1 per step).
REQ-010 cmd_steps  input  STEPS_WIDTH  unsigned number of steps to issue.
REQ-011 cmd_period  input  PERIOD_WIDTH  unsigned clk cycles between consecutive step rises.
REQ-012 step  output  1  registered step pulse to step_dir.
REQ-013 dir  output  1  registered direction to step_dir.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle pulse on command completion.
REQ-016 pos  output  32  signed position, two's complement.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, HIGH, LOW; cmd_ready = (state == IDLE) && !sclr (&& !abort when enabled).
REQ-018 On acceptance, dir SHALL take cmd_dir at the same edge, the step count and the effective period SHALL be latched, and the next state SHALL be SETUP.
REQ-019 Effective period SHALL be max(cmd_period, 2*PULSE_WIDTH).
REQ-020 SETUP SHALL last DIR_SETUP cycles; step SHALL rise exactly DIR_SETUP cycles after acceptance.
REQ-021 HIGH SHALL hold step=1 for exactly PULSE_WIDTH cycles; LOW SHALL hold step=0 for (period - PULSE_WIDTH) cycles, so consecutive rises are exactly period cycles apart.
REQ-022 pos SHALL change by +1 (dir=0) or -1 (dir=1) in the cycle step rises, wrapping from 0x7FFFFFFF to 0x80000000 and vice versa.
REQ-023 After the LOW phase of the last step, the FSM SHALL return to IDLE with done=1 for exactly that one cycle.
REQ-024 cmd_steps = 0 SHALL be accepted, update dir, issue no step, and return to IDLE with a done pulse at the end of SETUP.
REQ-025 A new command SHALL be accepted in the cycle after done; dir SHALL hold its last value while in IDLE.
REQ-026 Command inputs SHALL be ignored except on the acceptance cycle.

Reset
REQ-027 While sclr=1: state=IDLE, step=0, dir=0, busy=0, done=0, pos=0, cmd_ready=0; sclr mid-operation SHALL truncate any step pulse immediately and emit no done.

Configuration
REQ-028 With STEP_GEN_ABORT_EN defined, an input abort (1 bit) SHALL exist: in SETUP or LOW the FSM returns to IDLE at the next edge with done=1; in HIGH the pulse completes its PULSE_WIDTH first, then the FSM returns to IDLE with done=1; ignored in IDLE; abort=1 blocks acceptance.
REQ-029 Without STEP_GEN_ABORT_EN there SHALL be no abort port, and commands always run to completion.

Structure
REQ-030 The FSM state enum and default width constants SHALL reside in the shared package cnc_pkg.
REQ-031 The period/pulse down-counter SHALL be a sub-module step_gen_timer (load, count-down, zero flag).

Verification
REQ-032 PULSE_WIDTH=4, DIR_SETUP=2; accept steps=3, period=10, dir=0 at cycle 0 -> step rises at cycles 2, 12, 22, each 4 cycles high; pos 0->3; done at cycle 32 only.
REQ-033 steps=2, period=3, dir=1 -> period clamped to 8; rises at cycles 2 and 10; pos -2.
REQ-034 steps=0, dir=1 -> dir=1, no step, done pulse at cycle 2, busy high for cycles 0-1.
REQ-035 pos preset to 0x7FFFFFFF by 0x7FFFFFFF forward steps (or a force), then steps=1, dir=0 -> pos=0x80000000.
REQ-036 sclr asserted during the second cycle of a step pulse -> step=0, pos=0, busy=0 next cycle; no done pulse.
REQ-037 (STEP_GEN_ABORT_EN) abort during the first HIGH cycle -> step stays high 4 cycles total, then done, IDLE; abort in LOW -> IDLE and done at the next edge.
